// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_MIPS32 post-run helpers.
package mips32_pkg;

   localparam int unsigned REG_COUNT  = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } dump_state_t;

endpackage

// File: rtl/mips32_reg_dump.sv
// Post-run register-bank reader: on a rising HALTED it walks R0..R(NUM_REGS-1)
// through one register-file read port and streams {index, value} over valid/ready.
module mips32_reg_dump
   import mips32_pkg::*;
#(
   parameter int unsigned NUM_REGS = mips32_pkg::REG_COUNT,
   parameter int unsigned DATA_W   = mips32_pkg::DATA_W,
   parameter int unsigned ADDR_W   = mips32_pkg::REG_ADDR_W
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              halted,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_t       state;
   logic [ADDR_W-1:0] idx;
   logic              halted_q;
   logic              halt_rise;

   assign halt_rise  = halted & ~halted_q;
   assign rf_rd_addr = idx;

   // Dump sequencer; a falling HALTED during READ/SEND aborts without raising done.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         halted_q  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         halted_q <= halted;
         case (state)
            IDLE: begin
               if (halt_rise) begin
                  state <= READ;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            READ: begin
               if (!halted) begin
                  state     <= IDLE;
                  idx       <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  out_data  <= rf_rd_data;
                  out_idx   <= idx;
                  out_valid <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (!halted) begin
                  state     <= IDLE;
                  idx       <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     idx   <= idx + ADDR_W'(1);
                     state <= READ;
                  end
               end
            end
            DONE: begin
               if (!halted) begin
                  state <= IDLE;
                  done  <= 1'b0;
                  idx   <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               idx       <= '0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_reg_dump.sv
// Self-checking bench for mips32_reg_dump with a 6-register dump.
module tb_mips32_reg_dump;

   localparam int unsigned N  = 6;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk1 = 1'b0;
   logic          rst;
   logic          halted;
   logic          out_ready;
   logic          out_valid;
   logic          busy;
   logic          done;
   logic [AW-1:0] rf_rd_addr;
   logic [AW-1:0] out_idx;
   logic [DW-1:0] rf_rd_data;
   logic [DW-1:0] out_data;
   logic [DW-1:0] rf [32];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
      int            stall;
   } beat_t;

   beat_t vec [N];

   mips32_reg_dump #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk1      (clk1),
      .rst       (rst),
      .halted    (halted),
      .rf_rd_addr(rf_rd_addr),
      .rf_rd_data(rf_rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .busy      (busy),
      .done      (done)
   );

   assign rf_rd_data = rf[rf_rd_addr];

   always #5 clk1 = ~clk1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         step();
      end
      chk("valid_seen", 32'(out_valid), 32'd1);
   endtask

   // Wait for a beat, check it, optionally stall it, then hand it off.
   task automatic take_beat(input logic [AW-1:0] ei, input logic [DW-1:0] ed, input int stall);
      wait_valid();
      chk("beat_idx", 32'(out_idx), 32'(ei));
      chk("beat_data", out_data, ed);
      if (stall > 0) begin
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_idx", 32'(out_idx), 32'(ei));
            chk("hold_data", out_data, ed);
         end
      end
      out_ready = 1'b1;
      step();
      chk("valid_drop", 32'(out_valid), 32'd0);
   endtask

   task automatic end_dump();
      halted = 1'b0;
      step();
      chk("done_clear", 32'(done), 32'd0);
      step();
   endtask

   task automatic run_table();
      halted = 1'b1;
      step();
      chk("busy_start", 32'(busy), 32'd1);
      for (int k = 0; k < int'(N); k++) take_beat(vec[k].idx, vec[k].data, vec[k].stall);
      chk("done_set", 32'(done), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] model [N];
      int            exp_next;
      bit            accepted;

      for (int i = 0; i < 32; i++) rf[i] = 32'hdead0000 + 32'(i);
      rf[0] = 32'd0;  rf[1] = 32'd10; rf[2] = 32'd20;
      rf[3] = 32'd25; rf[4] = 32'd30; rf[5] = 32'd55;
      for (int k = 0; k < int'(N); k++) begin
         vec[k].idx   = AW'(k);
         vec[k].data  = rf[k];
         vec[k].stall = 0;
      end

      // Reset and idle
      rst = 1'b1; halted = 1'b0; out_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
      end

      // Straight dump, sink always ready
      run_table();
      end_dump();

      // Backpressure on idx 2
      vec[2].stall = 3;
      run_table();
      vec[2].stall = 0;
      end_dump();

      // Abort while idx 3 pending, then restart from idx 0
      halted = 1'b1;
      for (int k = 0; k < 3; k++) take_beat(AW'(k), rf[k], 0);
      wait_valid();
      chk("abort_pending_idx", 32'(out_idx), 32'd3);
      out_ready = 1'b0;
      halted = 1'b0;
      step();
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      step();
      out_ready = 1'b1;
      halted = 1'b1;
      for (int k = 0; k < int'(N); k++) take_beat(AW'(k), rf[k], 0);
      chk("restart_done", 32'(done), 32'd1);
      end_dump();

      // Async reset mid-SEND
      halted = 1'b1; out_ready = 1'b0;
      wait_valid();
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      halted = 1'b0;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();

      // halted high across reset release: exactly one dump
      rst = 1'b1; halted = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < int'(N); k++) take_beat(AW'(k), rf[k], 0);
      chk("hold_done", 32'(done), 32'd1);
      for (int i = 0; i < 20; i++) begin
         step();
         if (i % 5 == 4) begin
            chk("no_redump_valid", 32'(out_valid), 32'd0);
            chk("no_redump_done", 32'(done), 32'd1);
            chk("no_redump_busy", 32'(busy), 32'd0);
         end
      end
      end_dump();

      // Random data and random sink readiness against an in-order beat model
      for (int it = 0; it < 5; it++) begin
         for (int k = 0; k < int'(N); k++) begin
            rf[k]    = $urandom;
            model[k] = rf[k];
         end
         exp_next = 0;
         halted   = 1'b1;
         for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) break;
            out_ready = 1'($urandom_range(0, 1));
            accepted  = 1'b0;
            if (out_valid) begin
               chk("rnd_idx", 32'(out_idx), 32'(exp_next));
               if (exp_next < int'(N)) chk("rnd_data", out_data, model[exp_next]);
               accepted = out_ready;
            end
            step();
            if (accepted) exp_next++;
         end
         chk("rnd_count", 32'(exp_next), 32'(N));
         chk("rnd_done", 32'(done), 32'd1);
         out_ready = 1'b1;
         end_dump();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
